// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and counter encodings for the two-level local branch predictor
package bp_pkg;

  // 2-bit saturating direction counter held in each PHT entry
  typedef logic [1:0] pht_ctr_t;

  localparam pht_ctr_t PHT_STRONG_NT = 2'b00;
  localparam pht_ctr_t PHT_WEAK_NT   = 2'b01;
  localparam pht_ctr_t PHT_WEAK_T    = 2'b10;
  localparam pht_ctr_t PHT_STRONG_T  = 2'b11;

  // Fresh counters lean not-taken but flip after a single taken branch
  localparam pht_ctr_t PHT_RESET     = PHT_WEAK_NT;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// rtl/branch_predictor_sat_counter2.sv - next-state function of a 2-bit saturating direction counter
import bp_pkg::*;

module sat_counter2 (
  input  pht_ctr_t cur,
  input  logic     taken,
  output pht_ctr_t nxt
);

  // Step toward taken or not-taken, holding at the strong ends instead of wrapping
  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != PHT_STRONG_T) nxt = cur + 2'd1;
    end else begin
      if (cur != PHT_STRONG_NT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - two-level local branch predictor (optional statistics under BP_STATS_EN)
import bp_pkg::*;

module branch_predictor #(
  parameter int PC_HASH_BITS   = 3,
  parameter int PHT_INDEX_BITS = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pcF,
  output logic                      predict_takeF,
  output logic [PC_HASH_BITS-1:0]   pc_hashingF,
  output logic [PHT_INDEX_BITS-1:0] PHT_indexF,
  input  logic                      branchM,
  input  logic                      actually_takenM,
  input  logic                      predict_resultM,
  input  logic [PC_HASH_BITS-1:0]   pc_hashingM,
  input  logic [PHT_INDEX_BITS-1:0] PHT_indexM
`ifdef BP_STATS_EN
  ,
  output logic [31:0]               stat_branchesW,
  output logic [31:0]               stat_mispredictsW
`endif
);

  localparam int BHT_ENTRIES = 1 << PC_HASH_BITS;
  localparam int PHT_ENTRIES = 1 << PHT_INDEX_BITS;

  // Tables are flops so reset can clear every entry at once
  logic [PHT_INDEX_BITS-1:0] bht [BHT_ENTRIES];
  pht_ctr_t                  pht [PHT_ENTRIES];
  pht_ctr_t                  phtNext;

  // Only the low PC bits feed the hash and index; the rest are deliberately ignored
  logic unusedPcBits;
  assign unusedPcBits = ^pcF;

  // Fetch-side lookup is purely combinational so the prediction is ready in IF
  assign pc_hashingF   = pcF[PC_HASH_BITS+1:2] ^ pcF[2*PC_HASH_BITS+1:PC_HASH_BITS+2];
  assign PHT_indexF    = bht[pc_hashingF] ^ pcF[PHT_INDEX_BITS+1:2];
  assign predict_takeF = pht[PHT_indexF][1];

  sat_counter2 u_sat (
    .cur   (pht[PHT_indexM]),
    .taken (actually_takenM),
    .nxt   (phtNext)
  );

  // Train the counter and shift the outcome into the local history when MEM resolves a branch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= PHT_RESET;
      for (int j = 0; j < BHT_ENTRIES; j++) bht[j] <= '0;
    end else if (branchM) begin
      pht[PHT_indexM]  <= phtNext;
      bht[pc_hashingM] <= {bht[pc_hashingM][PHT_INDEX_BITS-2:0], actually_takenM};
    end
  end

`ifdef BP_STATS_EN
  // Count resolved branches and those whose prediction was wrong; both wrap freely
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branchesW    <= '0;
      stat_mispredictsW <= '0;
    end else if (branchM) begin
      stat_branchesW <= stat_branchesW + 32'd1;
      if (!predict_resultM) stat_mispredictsW <= stat_mispredictsW + 32'd1;
    end
  end
`else
  // Correctness flag only feeds the statistics, which are absent in this build
  logic unusedPredictResult;
  assign unusedPredictResult = predict_resultM;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic        predict_takeF;
  logic [2:0]  pc_hashingF;
  logic [6:0]  PHT_indexF;
  logic        branchM;
  logic        actually_takenM;
  logic        predict_resultM;
  logic [2:0]  pc_hashingM;
  logic [6:0]  PHT_indexM;
`ifdef BP_STATS_EN
  logic [31:0] stat_branchesW;
  logic [31:0] stat_mispredictsW;
`endif

  branch_predictor #(.PC_HASH_BITS(3), .PHT_INDEX_BITS(7)) dut (
    .clk             (clk),
    .rst             (rst),
    .pcF             (pcF),
    .predict_takeF   (predict_takeF),
    .pc_hashingF     (pc_hashingF),
    .PHT_indexF      (PHT_indexF),
    .branchM         (branchM),
    .actually_takenM (actually_takenM),
    .predict_resultM (predict_resultM),
    .pc_hashingM     (pc_hashingM),
    .PHT_indexM      (PHT_indexM)
`ifdef BP_STATS_EN
    ,
    .stat_branchesW    (stat_branchesW),
    .stat_mispredictsW (stat_mispredictsW)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] hash;
    logic [6:0] idx;
    logic       pred;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  hash;
    logic [6:0]  idx;
  } vec_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;

  logic [6:0]  mBht [8];
  logic [1:0]  mPht [128];
  logic [31:0] mBr;
  logic [31:0] mMis;

  task automatic check1(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] satNext(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  function automatic logic [2:0] mHash(input logic [31:0] pc);
    return pc[4:2] ^ pc[7:5];
  endfunction

  function automatic logic [6:0] mIdx(input logic [31:0] pc);
    return mBht[mHash(pc)] ^ pc[8:2];
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 128; i++) mPht[i] = 2'b01;
    for (int i = 0; i < 8; i++) mBht[i] = 7'h00;
    mBr = 0;
    mMis = 0;
  endtask

  task automatic pushConst(input string nm, input logic [2:0] h, input logic [6:0] ix, input logic p);
    exp_t e;
    e.name = nm; e.hash = h; e.idx = ix; e.pred = p;
    sbq.push_back(e);
  endtask

  task automatic popCompare();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check1({e.name, "_hash"}, {29'd0, pc_hashingF}, {29'd0, e.hash});
      check1({e.name, "_idx"},  {25'd0, PHT_indexF},  {25'd0, e.idx});
      check1({e.name, "_pred"}, {31'd0, predict_takeF}, {31'd0, e.pred});
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1
  task automatic cycle(input string nm, input logic [31:0] pc, input logic br, input logic tk,
                       input logic pr, input logic [2:0] hM, input logic [6:0] iM, input int expPred);
    exp_t e;
    pcF = pc; branchM = br; actually_takenM = tk; predict_resultM = pr;
    pc_hashingM = hM; PHT_indexM = iM;
    e.name = nm; e.hash = mHash(pc); e.idx = mIdx(pc); e.pred = mPht[e.idx][1];
    sbq.push_back(e);
    if (expPred >= 0) begin
      e.name = {nm, "_dir"}; e.pred = expPred[0];
      sbq.push_back(e);
    end
    @(negedge clk);
    popCompare();
    @(posedge clk);
    if (br) begin
      mPht[iM] = satNext(mPht[iM], tk);
      mBht[hM] = {mBht[hM][5:0], tk};
      mBr++;
      if (!pr) mMis++;
    end
    #1;
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{32'h0040_0010, 3'd4, 7'h04};
    vecs[1] = '{32'h0000_0000, 3'd0, 7'h00};
    vecs[2] = '{32'h0000_01FC, 3'd0, 7'h7F};
    vecs[3] = '{32'h0000_0064, 3'd2, 7'h19};
    vecs[4] = '{32'hFFFF_FFFC, 3'd0, 7'h7F};
    vecs[5] = '{32'h0000_00A8, 3'd7, 7'h2A};

    modelReset();
    rst = 1'b0; pcF = 32'h0040_0010; branchM = 1'b1; actually_takenM = 1'b1;
    predict_resultM = 1'b0; pc_hashingM = 3'd4; PHT_indexM = 7'h04;
    #3;
    pushConst("reset", 3'd4, 7'h04, 1'b0);
    popCompare();
    repeat (2) @(posedge clk);
    #1;
    pushConst("reset_held", 3'd4, 7'h04, 1'b0);
    popCompare();
`ifdef BP_STATS_EN
    check1("reset_stat_br", stat_branchesW, 32'd0);
    check1("reset_stat_mis", stat_mispredictsW, 32'd0);
`endif
    branchM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Post-reset lookup table
    for (int i = 0; i < 6; i++) begin
      pushConst($sformatf("vec%0d", i), vecs[i].hash, vecs[i].idx, 1'b0);
      cycle($sformatf("vec%0d_m", i), vecs[i].pc, 1'b0, 1'b0, 1'b1, 3'd0, 7'h00, 0);
    end

    // Saturation at index 04
    for (int i = 0; i < 3; i++)
      cycle($sformatf("sat_t%0d", i), 32'h10, 1'b1, 1'b1, 1'b1, 3'd0, 7'h04, (i == 0) ? 0 : 1);
    cycle("sat_top", 32'h10, 1'b0, 1'b0, 1'b1, 3'd0, 7'h00, 1);
    for (int i = 0; i < 4; i++)
      cycle($sformatf("sat_n%0d", i), 32'h10, 1'b1, 1'b0, 1'b0, 3'd0, 7'h04, (i < 2) ? 1 : 0);
    cycle("sat_bot", 32'h10, 1'b0, 1'b0, 1'b1, 3'd0, 7'h00, 0);
    cycle("sat_up1", 32'h10, 1'b1, 1'b1, 1'b1, 3'd0, 7'h04, 0);
    cycle("sat_up2", 32'h10, 1'b0, 1'b0, 1'b1, 3'd0, 7'h00, 0);

    // Local history at BHT slot 3
    for (int i = 0; i < 7; i++)
      cycle($sformatf("hist%0d", i), 32'h0C, 1'b1, 1'b1, 1'b1, 3'd3, 7'h10, -1);
    pushConst("hist_full", 3'd3, 7'h7C, 1'b0);
    cycle("hist_full_m", 32'h0C, 1'b1, 1'b1, 1'b1, 3'd3, 7'h10, -1);
    pushConst("hist_sat", 3'd3, 7'h7C, 1'b0);
    cycle("hist_nt", 32'h0C, 1'b1, 1'b0, 1'b1, 3'd3, 7'h10, -1);
    pushConst("hist_shift", 3'd3, 7'h7D, 1'b0);
    cycle("hist_shift_m", 32'h0C, 1'b0, 1'b0, 1'b1, 3'd0, 7'h00, -1);

    // Same-edge read and write of PHT[05]
    pushConst("rw_old", 3'd5, 7'h05, 1'b0);
    cycle("rw_old_m", 32'h14, 1'b1, 1'b1, 1'b1, 3'd6, 7'h05, 0);
    pushConst("rw_new", 3'd5, 7'h05, 1'b1);
    cycle("rw_new_m", 32'h14, 1'b0, 1'b0, 1'b1, 3'd0, 7'h00, 1);

    // branchM low with arbitrary M inputs must leave the tables alone
    for (int i = 0; i < 20; i++)
      cycle("idle", $urandom, 1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 7'($urandom), -1);
    for (int i = 0; i < 128; i++)
      cycle("sweep", 32'(i) << 2, 1'b0, 1'b0, 1'b1, 3'd0, 7'h00, -1);

    // Random training mixed with fetches
    for (int i = 0; i < 60; i++)
      cycle("rand", $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 7'($urandom), -1);
`ifdef BP_STATS_EN
    check1("stat_br_run", stat_branchesW, mBr);
    check1("stat_mis_run", stat_mispredictsW, mMis);
`endif

    // Asynchronous reset landing mid-update
    pcF = 32'h0C; branchM = 1'b1; actually_takenM = 1'b1; predict_resultM = 1'b0;
    pc_hashingM = 3'd3; PHT_indexM = 7'h03;
    #2;
    rst = 1'b0;
    #1;
    pushConst("midrst", 3'd3, 7'h03, 1'b0);
    popCompare();
`ifdef BP_STATS_EN
    check1("midrst_stat_br", stat_branchesW, 32'd0);
    check1("midrst_stat_mis", stat_mispredictsW, 32'd0);
`endif
    @(posedge clk);
    #1;
    modelReset();
    branchM = 1'b0;
    rst = 1'b1;
    pushConst("after_rst", 3'd3, 7'h03, 1'b0);
    cycle("after_rst_m", 32'h0C, 1'b0, 1'b0, 1'b1, 3'd0, 7'h00, 0);

`ifdef BP_STATS_EN
    // Ten branches, three of them mispredicted
    for (int i = 0; i < 10; i++)
      cycle("stat10", 32'h40, 1'b1, 1'(i & 1), (i == 2 || i == 5 || i == 8) ? 1'b0 : 1'b1,
            3'(i), 7'(i + 32), -1);
    check1("stat_br10", stat_branchesW, 32'd10);
    check1("stat_mis3", stat_mispredictsW, 32'd3);
    cycle("stat_hold", 32'h40, 1'b0, 1'b0, 1'b0, 3'd0, 7'h00, -1);
    check1("stat_br_hold", stat_branchesW, 32'd10);
    check1("stat_mis_hold", stat_mispredictsW, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
